// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: a CPU-fed TX FIFO drives the transmitter one byte at a time,
// and an RX holding register with an interrupt sits behind four fixed I/O addresses.
module uart_mmio_ctrl #(
   parameter int         TX_DEPTH    = 4,
   parameter logic [7:0] ADDR_INTACK = 8'd252,
   parameter logic [7:0] ADDR_TXD    = 8'd253,
   parameter logic [7:0] ADDR_RXD    = 8'd254,
   parameter logic [7:0] ADDR_STAT   = 8'd255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] access_addr,
   input  logic       reg_w_en,
   input  logic       reg_r_en,
   input  logic [7:0] w_data,
   output logic [7:0] r_data,
   output logic       int_req,
   output logic       uart_tx_en,
   output logic       uart_rx_en,
   output logic       uart_begin_flag,
   output logic [7:0] uart_tx_data,
   input  logic       uart_busy_flag,
   input  logic [7:0] uart_rx_data,
   input  logic       uart_receive_flag
);

   localparam int PW = $clog2(TX_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(TX_DEPTH);

   typedef enum logic [1:0] {T_IDLE, T_START, T_WAITB, T_WAITD} tx_state_t;

   tx_state_t     state, state_nxt;
   logic [7:0]    fifo_mem [TX_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic [3:0]    wait_cnt;
   logic [7:0]    rx_buf;
   logic          rx_full, overrun, tx_ovf, rx_prev;

   logic tx_full, tx_active, push, push_ok, pop;
   logic capture, rx_read, int_ack;
   logic [7:0] stat;

   assign tx_full   = (count == FULL_CNT);
   assign tx_active = (count != '0) || (state != T_IDLE);
   assign push      = reg_w_en && (access_addr == ADDR_TXD);
   assign push_ok   = push && !tx_full;
   assign pop       = (state == T_IDLE) && (count != '0) && !uart_busy_flag;
   assign capture   = uart_receive_flag && !rx_prev;
   assign rx_read   = reg_r_en && (access_addr == ADDR_RXD);
   assign int_ack   = reg_w_en && (access_addr == ADDR_INTACK);
   assign stat      = {3'b000, tx_ovf, overrun, rx_full, tx_full, tx_active};

   // NOTE: storage arrays carry no reset; pointers and count alone define validity, and an
   // unreset array maps onto plain RAM instead of a flop bank with reset muxes.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= w_data;
   end

   // NOTE: every sequential block uses non-blocking assignments so all registers update from
   // the same pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= T_IDLE;
         wait_cnt     <= '0;
         uart_tx_data <= '0;
         uart_tx_en   <= 1'b0;
         uart_rx_en   <= 1'b0;
      end else begin
         state      <= state_nxt;
         uart_tx_en <= 1'b1;
         uart_rx_en <= 1'b1;
         if (pop) uart_tx_data <= fifo_mem[rd_ptr];
         wait_cnt <= (state == T_WAITB) ? wait_cnt + 1'b1 : '0;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt       = state;
      uart_begin_flag = 1'b0;
      case (state)
         T_IDLE:  if (pop) state_nxt = T_START;
         T_START: begin
            uart_begin_flag = 1'b1;
            state_nxt       = T_WAITB;
         end
         // Give up on the busy handshake after 16 cycles so a missed pulse cannot hang TX.
         T_WAITB: if (uart_busy_flag || wait_cnt == 4'd15) state_nxt = T_WAITD;
         T_WAITD: if (!uart_busy_flag) state_nxt = T_IDLE;
         default: state_nxt = T_IDLE;
      endcase
   end

   // A capture takes priority over a same-cycle read or acknowledge so no byte goes unflagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_prev <= 1'b0;
         rx_buf  <= '0;
         rx_full <= 1'b0;
         overrun <= 1'b0;
         tx_ovf  <= 1'b0;
         int_req <= 1'b0;
      end else begin
         rx_prev <= uart_receive_flag;
         if (capture) rx_buf <= uart_rx_data;

         if (capture)      rx_full <= 1'b1;
         else if (rx_read) rx_full <= 1'b0;

         if (capture && rx_full)     overrun <= 1'b1;
         else if (int_ack && w_data[1]) overrun <= 1'b0;

         if (push && tx_full)        tx_ovf <= 1'b1;
         else if (int_ack && w_data[1]) tx_ovf <= 1'b0;

         if (capture)      int_req <= 1'b1;
         else if (int_ack) int_req <= 1'b0;
      end
   end

   always_comb begin
      r_data = '0;
      if (access_addr == ADDR_RXD)       r_data = rx_buf;
      else if (access_addr == ADDR_STAT) r_data = stat;
   end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: TX bytes checked against a scoreboard queue at each
// begin_flag, RX/status/interrupt behaviour checked at fixed points.
module tb_uart_mmio_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] access_addr = '0;
   logic       reg_w_en = 1'b0;
   logic       reg_r_en = 1'b0;
   logic [7:0] w_data = '0;
   logic [7:0] r_data;
   logic       int_req, uart_tx_en, uart_rx_en, uart_begin_flag;
   logic [7:0] uart_tx_data;
   logic       uart_busy_flag;
   logic [7:0] uart_rx_data = '0;
   logic       uart_receive_flag = 1'b0;

   logic       force_busy = 1'b0;
   logic       model_en   = 1'b1;
   logic       model_busy = 1'b0;
   int         busy_cnt   = 0;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_tx_q[$];
   logic [7:0] exp_rx_q[$];

   assign uart_busy_flag = force_busy | model_busy;

   always #10 clk = ~clk;

   uart_mmio_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .access_addr       (access_addr),
      .reg_w_en          (reg_w_en),
      .reg_r_en          (reg_r_en),
      .w_data            (w_data),
      .r_data            (r_data),
      .int_req           (int_req),
      .uart_tx_en        (uart_tx_en),
      .uart_rx_en        (uart_rx_en),
      .uart_begin_flag   (uart_begin_flag),
      .uart_tx_data      (uart_tx_data),
      .uart_busy_flag    (uart_busy_flag),
      .uart_rx_data      (uart_rx_data),
      .uart_receive_flag (uart_receive_flag)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Transmitter model: busy goes high at the begin pulse and stays high for 6 cycles.
   always @(negedge clk) begin
      if (model_en && uart_begin_flag) busy_cnt = 6;
      else if (busy_cnt > 0)           busy_cnt = busy_cnt - 1;
      model_busy = (busy_cnt != 0);
   end

   // Scoreboard: every begin pulse must match the oldest byte still expected.
   always @(negedge clk) begin
      if (uart_begin_flag) begin
         check("tx_begin_expected", 32'(exp_tx_q.size() > 0), 32'd1);
         if (exp_tx_q.size() > 0) check("tx_data", uart_tx_data, exp_tx_q.pop_front());
      end
   end

   // Strobes are set at a negedge and dropped one full cycle later, so calls chain back-to-back.
   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      access_addr = a; w_data = d; reg_w_en = 1'b1;
      @(negedge clk);
      reg_w_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      access_addr = a; reg_r_en = 1'b1;
      #1 d = r_data;
      @(negedge clk);
      reg_r_en = 1'b0;
   endtask

   task automatic peek(input logic [7:0] a, output logic [7:0] d);
      access_addr = a;
      #1 d = r_data;
   endtask

   task automatic rx_pulse(input logic [7:0] d);
      uart_rx_data = d; uart_receive_flag = 1'b1;
      exp_rx_q.push_back(d);
      @(negedge clk);
      uart_receive_flag = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_tx_idle(input string tag);
      logic [7:0] s;
      logic       done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         peek(8'd255, s);
         if (!s[0] && exp_tx_q.size() == 0) done = 1'b1;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   initial begin
      logic [7:0] s, d;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      peek(8'd255, s);
      check("rst_stat", s, 8'h00);
      check("rst_int_req", int_req, 1'b0);
      check("rst_begin", uart_begin_flag, 1'b0);
      check("rst_tx_data", uart_tx_data, 8'h00);
      check("rst_tx_en", uart_tx_en, 1'b0);
      check("rst_rx_en", uart_rx_en, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("run_tx_en", uart_tx_en, 1'b1);
      check("run_rx_en", uart_rx_en, 1'b1);

      // 1: single byte with tx idle
      exp_tx_q.push_back(8'h41);
      wr(8'd253, 8'h41);
      @(negedge clk);
      check("t1_begin_pulse", uart_begin_flag, 1'b1);
      @(negedge clk);
      check("t1_begin_one_cycle", uart_begin_flag, 1'b0);
      peek(8'd255, s);
      check("t1_active_while_busy", s[0], 1'b1);
      wait_tx_idle("t1_idle");

      // 2: FIFO fill with busy held, fifth byte dropped, then drain in order
      force_busy = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_tx_q.push_back(8'(i));
         wr(8'd253, 8'(i));
      end
      peek(8'd255, s);
      check("t2_stat_full_ovf", s, 8'h13);
      force_busy = 1'b0;
      wait_tx_idle("t2_drain");
      wr(8'd252, 8'h02);
      peek(8'd255, s);
      check("t2_ovf_cleared", s, 8'h00);

      // Busy never rises: the WAITB guard must release the FSM after about 16 cycles
      model_en = 1'b0;
      exp_tx_q.push_back(8'h77);
      wr(8'd253, 8'h77);
      n = 0;
      d = 8'h01;
      for (int i = 0; i < 60 && d[0]; i++) begin
         @(negedge clk);
         peek(8'd255, d);
         if (d[0]) n++;
      end
      check("tmo_active_len_ok", 32'(n >= 16 && n <= 20), 32'd1);
      check("tmo_idle", d[0], 1'b0);
      model_en = 1'b1;

      // 3: single receive, read, acknowledge
      rx_pulse(8'h5A);
      check("t3_int_req", int_req, 1'b1);
      peek(8'd255, s);
      check("t3_rx_full", s[2], 1'b1);
      peek(8'd253, s);
      check("t3_unmapped_zero", s, 8'h00);
      rd(8'd254, d);
      check("t3_rxd", d, exp_rx_q[$]);
      exp_rx_q.delete();
      peek(8'd255, s);
      check("t3_rx_full_cleared", s[2], 1'b0);
      check("t3_int_req_held", int_req, 1'b1);
      wr(8'd252, 8'h00);
      check("t3_int_ack", int_req, 1'b0);

      // 4: overrun
      rx_pulse(8'h11);
      rx_pulse(8'h22);
      rd(8'd254, d);
      check("t4_rxd_latest", d, exp_rx_q[$]);
      exp_rx_q.delete();
      peek(8'd255, s);
      check("t4_overrun", s[3], 1'b1);
      wr(8'd252, 8'h02);
      peek(8'd255, s);
      check("t4_stat_cleared", s, 8'h00);
      check("t4_int_req", int_req, 1'b0);

      // 5: capture coinciding with INTACK, then with an RXD read
      @(negedge clk);
      uart_rx_data = 8'h33; uart_receive_flag = 1'b1;
      wr(8'd252, 8'h00);
      uart_receive_flag = 1'b0;
      check("t5_ack_int_req", int_req, 1'b1);
      peek(8'd255, s);
      check("t5_ack_rx_full", s[2], 1'b1);
      @(negedge clk);
      uart_rx_data = 8'h44; uart_receive_flag = 1'b1;
      rd(8'd254, d);
      uart_receive_flag = 1'b0;
      check("t5_read_old", d, 8'h33);
      peek(8'd255, s);
      check("t5_read_rx_full", s[2], 1'b1);
      check("t5_read_int_req", int_req, 1'b1);
      peek(8'd254, d);
      check("t5_new_data", d, 8'h44);

      // 6: reset during WAITD with three bytes queued
      exp_tx_q.push_back(8'hA0);
      wr(8'd253, 8'hA0);
      wr(8'd253, 8'hA1);
      wr(8'd253, 8'hA2);
      wr(8'd253, 8'hA3);
      check("t6_busy_in_flight", uart_busy_flag, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      peek(8'd255, s);
      check("t6_stat", s, 8'h00);
      check("t6_int_req", int_req, 1'b0);
      check("t6_tx_queue_seen", 32'(exp_tx_q.size()), 32'd0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      peek(8'd255, s);
      check("t6_stays_idle", s, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
